// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// The master side is the fetch/decode environment; the slave side is the queue itself.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_in;
    logic [31:0]   instr_in;
    logic          fetch_valid;
    logic          fetch_ready;
    logic          flush;
    logic          dec_valid;
    logic          dec_ready;
    logic [31:0]   dec_pc;
    logic [31:0]   dec_instr;
    logic [31:0]   dec_pc8;
    logic [CW-1:0] count;

    modport master (
        output pc_in, instr_in, fetch_valid, flush, dec_ready,
        input  fetch_ready, dec_valid, dec_pc, dec_instr, dec_pc8, count
    );

    modport slave (
        input  pc_in, instr_in, fetch_valid, flush, dec_ready,
        output fetch_ready, dec_valid, dec_pc, dec_instr, dec_pc8, count
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue between IF and ID; all outputs come straight from registers.
// Head-of-queue outputs are precomputed from next-state so decode sees a new entry right after its push edge.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [63:0]   mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          fetch_ready_r;
    logic          dec_valid_r;
    logic [31:0]   dec_pc_r;
    logic [31:0]   dec_instr_r;
    logic [31:0]   dec_pc8_r;

    logic          push_s;
    logic          pop_s;
    logic [PW-1:0] rd_next_s;
    logic [PW-1:0] wr_next_s;
    logic [CW-1:0] count_next_s;
    logic [31:0]   head_pc_s;
    logic [31:0]   head_instr_s;

    // Handshake qualification and next pointer/occupancy; flush discards any push or pop.
    always_comb begin
        push_s       = bus.fetch_valid & fetch_ready_r & ~bus.flush;
        pop_s        = dec_valid_r & bus.dec_ready & ~bus.flush;
        rd_next_s    = rd_ptr_r;
        wr_next_s    = wr_ptr_r;
        count_next_s = count_r;
        if (bus.flush) begin
            rd_next_s    = {PW{1'b0}};
            wr_next_s    = {PW{1'b0}};
            count_next_s = {CW{1'b0}};
        end else begin
            if (pop_s) begin
                rd_next_s = rd_ptr_r + PW'(1'b1);
            end else begin
                rd_next_s = rd_ptr_r;
            end
            if (push_s) begin
                wr_next_s = wr_ptr_r + PW'(1'b1);
            end else begin
                wr_next_s = wr_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CW'(1'b1);
                2'b01:   count_next_s = count_r - CW'(1'b1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // Next head entry; a word landing in the slot that becomes head is forwarded from the inputs.
    always_comb begin
        head_pc_s    = RESET_PC;
        head_instr_s = 32'h0000_0000;
        if (count_next_s == {CW{1'b0}}) begin
            head_pc_s    = RESET_PC;
            head_instr_s = 32'h0000_0000;
        end else if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_pc_s    = bus.pc_in;
            head_instr_s = bus.instr_in;
        end else begin
            head_pc_s    = mem_r[rd_next_s][63:32];
            head_instr_s = mem_r[rd_next_s][31:0];
        end
    end

    // Entry storage; contents are deliberately left untouched by reset and flush.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            mem_r[wr_ptr_r] <= {bus.pc_in, bus.instr_in};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy and registered decode-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            count_r       <= {CW{1'b0}};
            fetch_ready_r <= 1'b1;
            dec_valid_r   <= 1'b0;
            dec_pc_r      <= RESET_PC;
            dec_instr_r   <= 32'h0000_0000;
            dec_pc8_r     <= RESET_PC + 32'd8;
        end else begin
            rd_ptr_r      <= rd_next_s;
            wr_ptr_r      <= wr_next_s;
            count_r       <= count_next_s;
            fetch_ready_r <= (count_next_s != FULL_CNT);
            dec_valid_r   <= (count_next_s != {CW{1'b0}});
            dec_pc_r      <= head_pc_s;
            dec_instr_r   <= head_instr_s;
            dec_pc8_r     <= head_pc_s + 32'd8;
        end
    end

    assign bus.fetch_ready = fetch_ready_r;
    assign bus.dec_valid   = dec_valid_r;
    assign bus.dec_pc      = dec_pc_r;
    assign bus.dec_instr   = dec_instr_r;
    assign bus.dec_pc8     = dec_pc8_r;
    assign bus.count       = count_r;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();
    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [63:0] mq[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] m_pc();
        return (mq.size() != 0) ? mq[0][63:32] : RESET_PC;
    endfunction

    function automatic logic [31:0] m_instr();
        return (mq.size() != 0) ? mq[0][31:0] : 32'h0000_0000;
    endfunction

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic dr, input logic fl);
        bus.fetch_valid = fv;
        bus.pc_in       = pc;
        bus.instr_in    = ins;
        bus.dec_ready   = dr;
        bus.flush       = fl;
    endtask

    // Advance the reference model by the rules, then clock the DUT and settle.
    task automatic step();
        bit push, pop;
        if (reset) begin
            mq.delete();
        end else begin
            push = bus.fetch_valid && (mq.size() < DEPTH) && !bus.flush;
            pop  = bus.dec_ready && (mq.size() > 0) && !bus.flush;
            if (bus.flush) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back({bus.pc_in, bus.instr_in});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.dec_valid); end
        n_checks++; if (bus.fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.fetch_ready); end
        n_checks++; if (bus.dec_pc !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc: got %h expected 00003000", bus.dec_pc); end
        n_checks++; if (bus.dec_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", bus.dec_instr); end
        n_checks++; if (bus.dec_pc8 !== 32'h0000_3008) begin n_fail++; $display("FAIL reset_pc8: got %h expected 00003008", bus.dec_pc8); end
        reset = 1'b0;
    endtask

    task automatic test_streaming();
        logic [31:0] exp_pc;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h0000_3000 + 32'(4 * i);
            drive(1'b1, exp_pc, $urandom, 1'b1, 1'b0);
            step();
            n_checks++; if (bus.dec_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, bus.dec_pc, exp_pc); end
            n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, bus.count); end
            n_checks++; if (bus.dec_instr !== m_instr()) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, bus.dec_instr, m_instr()); end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b expected 0", bus.dec_valid); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0000_3000 + 32'(4 * i), $urandom, 1'b0, 1'b0);
            step();
            if (i == 3) begin
                n_checks++; if (bus.fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b expected 0", bus.fetch_ready); end
            end
        end
        n_checks++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", bus.count); end
        n_checks++; if (bus.dec_pc !== 32'h0000_3000) begin n_fail++; $display("FAIL fill_head: got %h expected 00003000", bus.dec_pc); end
        // Fifth word still offered while decode pops: it must be refused.
        bus.dec_ready = 1'b1;
        step();
        n_checks++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL fill_pop_count: got %0d expected 3", bus.count); end
        n_checks++; if (bus.fetch_ready !== 1'b1) begin n_fail++; $display("FAIL fill_pop_ready: got %b expected 1", bus.fetch_ready); end
        n_checks++; if (bus.dec_pc !== 32'h0000_3004) begin n_fail++; $display("FAIL fill_pop_pc: got %h expected 00003004", bus.dec_pc); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        n_checks++; if (bus.dec_pc !== 32'h0000_3008) begin n_fail++; $display("FAIL fill_drain1: got %h expected 00003008", bus.dec_pc); end
        step();
        n_checks++; if (bus.dec_pc !== 32'h0000_300C) begin n_fail++; $display("FAIL fill_drain2: got %h expected 0000300c", bus.dec_pc); end
        step();
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL fill_no_fifth: got count %0d expected 0", bus.count); end
    endtask

    task automatic test_wrap();
        logic [31:0] instr_tab [10];
        logic [31:0] popped [$];
        int pushed = 0;
        for (int k = 0; k < 10; k++) instr_tab[k] = $urandom;
        for (int c = 0; c < 300 && !(pushed == 10 && mq.size() == 0); c++) begin
            drive((pushed < 10) && ($urandom_range(0, 2) != 0), 32'h0000_3100 + 32'(4 * pushed),
                  instr_tab[pushed % 10], $urandom_range(0, 1) == 1, 1'b0);
            if (bus.dec_valid && bus.dec_ready) popped.push_back(bus.dec_pc);
            if (bus.fetch_valid && (mq.size() < DEPTH)) pushed++;
            step();
            n_checks++; if (int'(bus.count) !== mq.size()) begin n_fail++; $display("FAIL wrap_count c%0d: got %0d expected %0d", c, bus.count, mq.size()); end
            n_checks++; if (bus.dec_pc !== m_pc() || bus.dec_instr !== m_instr()) begin n_fail++; $display("FAIL wrap_head c%0d: got %h/%h expected %h/%h", c, bus.dec_pc, bus.dec_instr, m_pc(), m_instr()); end
            n_checks++; if (bus.fetch_ready !== (mq.size() != DEPTH) || bus.dec_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL wrap_flags c%0d: got ready %b valid %b expected size %0d", c, bus.fetch_ready, bus.dec_valid, mq.size()); end
            n_checks++; if (bus.dec_pc8 !== m_pc() + 32'd8) begin n_fail++; $display("FAIL wrap_pc8 c%0d: got %h expected %h", c, bus.dec_pc8, m_pc() + 32'd8); end
        end
        n_checks++; if (popped.size() != 10) begin n_fail++; $display("FAIL wrap_total: got %0d pops expected 10", popped.size()); end
        for (int k = 0; k < popped.size(); k++) begin
            n_checks++; if (popped[k] !== 32'h0000_3100 + 32'(4 * k)) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h expected %h", k, popped[k], 32'h0000_3100 + 32'(4 * k)); end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_3200 + 32'(4 * i), $urandom, 1'b0, 1'b0);
            step();
        end
        n_checks++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL flush_pre: got %0d expected 3", bus.count); end
        drive(1'b1, 32'h0000_5000, 32'hDEAD_BEEF, 1'b1, 1'b1);
        step();
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", bus.count); end
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", bus.dec_valid); end
        n_checks++; if (bus.fetch_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", bus.fetch_ready); end
        drive(1'b1, 32'h0000_4000, 32'h2402_0001, 1'b0, 1'b0);
        step();
        n_checks++; if (bus.dec_pc !== 32'h0000_4000) begin n_fail++; $display("FAIL flush_redirect_pc: got %h expected 00004000", bus.dec_pc); end
        n_checks++; if (bus.dec_pc8 !== 32'h0000_4008) begin n_fail++; $display("FAIL flush_redirect_pc8: got %h expected 00004008", bus.dec_pc8); end
        n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL flush_redirect_count: got %0d expected 1 (pushed word leaked?)", bus.count); end
        // Reset mid-stream drops everything, even with a push and pop requested.
        reset = 1'b1;
        drive(1'b1, 32'h0000_6000, 32'h0, 1'b1, 1'b0);
        step();
        reset = 1'b0;
        n_checks++; if (bus.count !== 3'd0 || bus.dec_pc !== RESET_PC) begin n_fail++; $display("FAIL midreset: got count %0d pc %h expected 0/%h", bus.count, bus.dec_pc, RESET_PC); end
    endtask

    task automatic test_pc8_wrap();
        drive(1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0);
        step();
        n_checks++; if (bus.dec_pc8 !== 32'h0000_0004) begin n_fail++; $display("FAIL pc8_wrap: got %h expected 00000004", bus.dec_pc8); end
        n_checks++; if (bus.dec_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL pc8_wrap_pc: got %h expected fffffffc", bus.dec_pc); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_streaming();
        test_fill();
        test_wrap();
        test_flush();
        test_pc8_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the PC/instruction-memory fetch stage and the decode stage of the MIPS pipeline. Each cycle it captures the current fetch address and the instruction word read for it, buffers up to DEPTH pairs in order, and presents the oldest pair to decode with a valid/ready handshake. It back-pressures fetch when full so the PC holds, and it discards all buffered work on a control-flow redirect (branch, jump, or exception).

## Interface

- DEPTH, 4, number of queue entries; power of two, at least 2
- RESET_PC, 32'h0000_3000, value of dec_pc while the queue is empty

- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- pc_in  input  32  address of the word currently being fetched
- instr_in  input  32  instruction memory read data for pc_in
- fetch_valid  input  1  pc_in/instr_in hold a valid fetch this cycle
- fetch_ready  output  1  queue not full; fetch may advance the PC
- flush  input  1  redirect; empties the queue at the next edge
- dec_valid  output  1  head entry valid
- dec_ready  input  1  decode consumes the head entry this cycle
- dec_pc  output  32  PC of the head entry
- dec_instr  output  32  instruction of the head entry
- dec_pc8  output  32  dec_pc + 8, the jal/jalr link value
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation

- Storage: DEPTH entries of {pc, instr}, a read pointer and a write pointer, each $clog2(DEPTH) bits wide, and an occupancy counter.
- Pointers wrap modulo DEPTH. Full is count==DEPTH and empty is count==0. Full and empty are never inferred from pointer equality alone.
- push = fetch_valid & fetch_ready & ~flush. A push writes to the write pointer slot and increments the write pointer.
- pop = dec_valid & dec_ready & ~flush. A pop increments the read pointer.
- Counter update: push only adds 1; pop only subtracts 1; push and pop together leave count unchanged.
- fetch_ready = (count != DEPTH). It is a function of count only. There is no combinational path from dec_ready or flush to fetch_ready. At full, push is refused even if a pop occurs in the same cycle.
- When full, upstream holds pc_in and instr_in stable until fetch_ready returns.
- dec_valid = (count != 0).
- When non-empty, dec_pc and dec_instr show the read pointer slot.
- When empty, dec_instr = 32'h0000_0000 (NOP) and dec_pc = RESET_PC.
- dec_pc8 = dec_pc + 32'd8, computed modulo 2^32 with the carry discarded.
- flush has top priority:
  - At the edge, both pointers and count go to 0.
  - Any push or pop requested in the flush cycle is discarded.
  - Entry contents are not cleared.
- Push of an entry while empty: there is no bypass. The entry appears on the dec_* outputs after the edge.

## Timing

- Reset state after the edge with reset=1: count=0, pointers=0, dec_valid=0, fetch_ready=1, dec_instr=0, dec_pc=RESET_PC, dec_pc8=RESET_PC+8.
- Reset overrides flush, push and pop in the same cycle. Reset asserted mid-stream drops all entries, exactly like flush.
- Latency: a pair pushed at edge N is visible on dec_* immediately after edge N, with dec_valid=1. This is a 1-cycle fetch-to-decode latency, matching a conventional IF/ID register.
- Throughput: 1 push and 1 pop per cycle are sustained whenever 0 < count < DEPTH.
- Outputs depend only on registered state. dec_* have no combinational dependence on fetch_* inputs.
- After a flush at edge N:
  - count=0, dec_valid=0 and fetch_ready=1 after edge N.
  - The first redirected fetch may push in cycle N+1.

## Test plan

- Reset then idle:
  - Apply reset for 2 cycles.
  - Require count=0, dec_valid=0, fetch_ready=1, dec_pc=32'h3000, dec_instr=0 and dec_pc8=32'h3008.
- Streaming with dec_ready=1:
  - Push pc 0x3000, 0x3004 and 0x3008 on consecutive cycles.
  - Require dec_pc to equal 0x3000, 0x3004, 0x3008 one cycle after each push, with count staying at 1.
- Fill and back-pressure with dec_ready=0:
  - Push 5 words.
  - Require fetch_ready=0 after the 4th push, the 5th word not stored, and count=4.
  - Raising dec_ready for one cycle pops 0x3000 and restores fetch_ready; count=3.
- Pointer wrap:
  - Run 10 pushes and pops interleaved randomly at DEPTH=4.
  - Require output order identical to input order, with wrap past slot 3 lossless.
- Flush with simultaneous push and pop at count=3:
  - Require count=0 and dec_valid=0 next cycle, and the pushed word absent.
  - A subsequent push of pc 0x4000 appears as dec_pc=0x4000 with dec_pc8=0x4008.
- dec_pc8 wrap:
  - Push pc 0xFFFF_FFFC.
  - Require dec_pc8=0x0000_0004.
